// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: shared types, default widths and helpers for the draw sequencer.
package draw_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Default pixel-path widths
    localparam int X_W_DEF = 9;
    localparam int Y_W_DEF = 8;
    localparam int C_W_DEF = 3;

    // Width of a channel index; never below one bit so a 2-channel build still has a port
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_seq_next_ch.sv
// draw_seq_next_ch: combinational priority finder. Returns the lowest set mask
// bit above start (or at/above start when inclusive is set).
module draw_seq_next_ch
    import draw_seq_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  start,
    input  logic              inclusive,
    output logic [IDX_W-1:0]  next_idx,
    output logic              found
);

    // Scan from the top down so the lowest qualifying index is the last one kept
    always_comb begin
        logic hit_s;
        next_idx = {IDX_W{1'b0}};
        found    = 1'b0;
        hit_s    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            hit_s    = mask[i] && ((IDX_W'(i) > start) ||
                                   (inclusive && (IDX_W'(i) == start)));
            next_idx = hit_s ? IDX_W'(i) : next_idx;
            found    = found | hit_s;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: launches each enabled drawer channel in ascending order on a
// go pulse, waits for each channel's done, and forwards the active channel's
// pixel stream to the VGA adapter through a registered mux.
// Optional watchdog: define DRAW_SEQ_TIMEOUT_EN to enable the per-channel timeout.
module draw_sequencer
    import draw_seq_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int C_W     = C_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      go,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic [NUM_CH-1:0]         ch_go,
    input  logic [NUM_CH-1:0]         ch_done,
    input  logic [NUM_CH*X_W-1:0]     ch_x,
    input  logic [NUM_CH*Y_W-1:0]     ch_y,
    input  logic [NUM_CH*C_W-1:0]     ch_color,
    input  logic [NUM_CH-1:0]         ch_plot,
    output logic [X_W-1:0]            x,
    output logic [Y_W-1:0]            y,
    output logic [C_W-1:0]            color,
    output logic                      plot,
    output logic [ch_idx_w(NUM_CH)-1:0] cur_ch,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);

    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [NUM_CH-1:0]   mask_r;
    logic [CH_W-1:0]     cur_ch_r;
    logic [NUM_CH-1:0]   ch_go_r;
    logic [X_W-1:0]      x_r;
    logic [Y_W-1:0]      y_r;
    logic [C_W-1:0]      color_r;
    logic                plot_r;
    logic                busy_r;
    logic                done_r;
    logic                timeout_err_r;

    logic [CH_W-1:0]     first_idx_s;
    logic                first_found_s;
    logic [CH_W-1:0]     next_idx_s;
    logic                next_found_s;

    logic [X_W-1:0]      sel_x_s;
    logic [Y_W-1:0]      sel_y_s;
    logic [C_W-1:0]      sel_color_s;
    logic                sel_plot_s;
    logic                done_cur_s;
    logic                wd_expire_s;
    logic                adv_s;

    // First enabled channel of a freshly sampled mask (used on every accepted go)
    draw_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_first (
        .mask      (ch_en),
        .start     ({CH_W{1'b0}}),
        .inclusive (1'b1),
        .next_idx  (first_idx_s),
        .found     (first_found_s)
    );

    // Next enabled channel strictly above the active one
    draw_seq_next_ch #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_next (
        .mask      (mask_r),
        .start     (cur_ch_r),
        .inclusive (1'b0),
        .next_idx  (next_idx_s),
        .found     (next_found_s)
    );

    // Select the active channel's pixel stream and done; out-of-range index gives zeros
    always_comb begin
        sel_x_s     = {X_W{1'b0}};
        sel_y_s     = {Y_W{1'b0}};
        sel_color_s = {C_W{1'b0}};
        sel_plot_s  = 1'b0;
        done_cur_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_x_s     = (cur_ch_r == CH_W'(i)) ? ch_x[i*X_W +: X_W]     : sel_x_s;
            sel_y_s     = (cur_ch_r == CH_W'(i)) ? ch_y[i*Y_W +: Y_W]     : sel_y_s;
            sel_color_s = (cur_ch_r == CH_W'(i)) ? ch_color[i*C_W +: C_W] : sel_color_s;
            sel_plot_s  = (cur_ch_r == CH_W'(i)) ? ch_plot[i]             : sel_plot_s;
            done_cur_s  = (cur_ch_r == CH_W'(i)) ? ch_done[i]             : done_cur_s;
        end
    end

`ifdef DRAW_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    logic [WD_W-1:0] wd_cnt_r;

    assign wd_expire_s = (state_r == ST_WAIT) && (wd_cnt_r == WD_W'(TIMEOUT - 1));

    // Per-channel watchdog: cleared while launching, counts every WAIT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (state_r == ST_LAUNCH) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // Channel completion (or watchdog expiry) while waiting moves the sequence on
    assign adv_s = (state_r == ST_WAIT) && (done_cur_s || wd_expire_s);

    // Sequencer FSM with registered launch/status/mux outputs; go always wins (restart)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            mask_r   <= {NUM_CH{1'b0}};
            cur_ch_r <= {CH_W{1'b0}};
            ch_go_r  <= {NUM_CH{1'b0}};
            x_r      <= {X_W{1'b0}};
            y_r      <= {Y_W{1'b0}};
            color_r  <= {C_W{1'b0}};
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            ch_go_r <= {NUM_CH{1'b0}};
            done_r  <= 1'b0;

            // Coordinates follow the active channel only while it is drawing
            if (state_r == ST_WAIT) begin
                x_r     <= sel_x_s;
                y_r     <= sel_y_s;
                color_r <= sel_color_s;
            end

            // Strobe is suppressed outside WAIT and on switch/restart edges
            plot_r <= ((state_r == ST_WAIT) && !go && !adv_s) ? sel_plot_s : 1'b0;

            if (go) begin
                mask_r <= ch_en;
                if (first_found_s) begin
                    cur_ch_r <= first_idx_s;
                    ch_go_r  <= ONE_HOT0 << first_idx_s;
                    state_r  <= ST_LAUNCH;
                    busy_r   <= 1'b1;
                end else begin
                    state_r  <= ST_FINISH;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_LAUNCH: begin
                        state_r <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (adv_s) begin
                            if (next_found_s) begin
                                cur_ch_r <= next_idx_s;
                                ch_go_r  <= ONE_HOT0 << next_idx_s;
                                state_r  <= ST_LAUNCH;
                            end else begin
                                state_r  <= ST_FINISH;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                            end
                        end
                    end
                    ST_FINISH: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky watchdog flag; only an accepted go from IDLE clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_r <= 1'b0;
        end else begin
`ifdef DRAW_SEQ_TIMEOUT_EN
            if (go && (state_r == ST_IDLE)) begin
                timeout_err_r <= 1'b0;
            end else if (wd_expire_s && !done_cur_s && !go) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
`else
            timeout_err_r <= 1'b0;
`endif
        end
    end

    assign ch_go       = ch_go_r;
    assign x           = x_r;
    assign y           = y_r;
    assign color       = color_r;
    assign plot        = plot_r;
    assign cur_ch      = cur_ch_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed self-checking bench for draw_sequencer (NUM_CH=3).
module tb_draw_sequencer;

    localparam int NUM_CH = 3;
    localparam int X_W    = 9;
    localparam int Y_W    = 8;
    localparam int C_W    = 3;

    logic                  clk;
    logic                  reset_n;
    logic                  go;
    logic [NUM_CH-1:0]     ch_en;
    logic [NUM_CH-1:0]     ch_go;
    logic [NUM_CH-1:0]     ch_done;
    logic [NUM_CH*X_W-1:0] ch_x;
    logic [NUM_CH*Y_W-1:0] ch_y;
    logic [NUM_CH*C_W-1:0] ch_color;
    logic [NUM_CH-1:0]     ch_plot;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [C_W-1:0]        color;
    logic                  plot;
    logic [1:0]            cur_ch;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;

    int          checks_cnt;
    int          fail_cnt;
    logic [2:0]  go_seen;

    draw_sequencer #(
        .NUM_CH  (NUM_CH),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .C_W     (C_W),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .ch_en       (ch_en),
        .ch_go       (ch_go),
        .ch_done     (ch_done),
        .ch_x        (ch_x),
        .ch_y        (ch_y),
        .ch_color    (ch_color),
        .ch_plot     (ch_plot),
        .x           (x),
        .y           (y),
        .color       (color),
        .plot        (plot),
        .cur_ch      (cur_ch),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        go_seen = go_seen | ch_go;
    endtask

    // Start a sequence: go for one edge with the given enable mask
    task automatic start(input logic [2:0] en);
        ch_en = en;
        go    = 1'b1;
        step();
        go    = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] d);
        ch_done = d;
        step();
        ch_done = 3'b000;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        go_seen    = 3'b000;
        reset_n    = 1'b0;
        go         = 1'b0;
        ch_en      = 3'b000;
        ch_done    = 3'b000;
        ch_x       = {(NUM_CH*X_W){1'b0}};
        ch_y       = {(NUM_CH*Y_W){1'b0}};
        ch_color   = {(NUM_CH*C_W){1'b0}};
        ch_plot    = 3'b000;

        // Reset state
        #12;
        check("rst_ch_go", ch_go, 32'd0);
        check("rst_busy",  busy,  32'd0);
        check("rst_done",  done,  32'd0);
        check("rst_cur",   cur_ch, 32'd0);
        check("rst_pix",   {x, y, color, plot}, 32'd0);
        check("rst_terr",  timeout_err, 32'd0);
        #1 reset_n = 1'b1;
        step();

        // All three channels in order
        go_seen = 3'b000;
        start(3'b111);
        check("all_go0",   ch_go, 32'b001);
        check("all_busy0", busy,  32'd1);
        check("all_cur0",  cur_ch, 32'd0);
        step();
        check("all_go_clr", ch_go, 32'd0);
        step();
        pulse_done(3'b001);
        check("all_go1",   ch_go, 32'b010);
        check("all_cur1",  cur_ch, 32'd1);
        check("all_busy1", busy,  32'd1);
        step();
        pulse_done(3'b010);
        check("all_go2",   ch_go, 32'b100);
        check("all_busy2", busy,  32'd1);
        step();
        pulse_done(3'b100);
        check("all_done",  done,  32'd1);
        check("all_busy_off", busy, 32'd0);
        step();
        check("all_done_1cyc", done, 32'd0);
        check("all_seen", go_seen, 32'b111);

        // Mask 101 skips channel 1
        go_seen = 3'b000;
        start(3'b101);
        check("skip_go0", ch_go, 32'b001);
        step();
        pulse_done(3'b001);
        check("skip_go2",  ch_go, 32'b100);
        check("skip_cur2", cur_ch, 32'd2);
        step();
        pulse_done(3'b100);
        check("skip_done", done, 32'd1);
        check("skip_seen", go_seen, 32'b101);
        step();

        // Empty mask: immediate done, no launch
        go_seen = 3'b000;
        start(3'b000);
        check("empty_done", done,  32'd1);
        check("empty_go",   ch_go, 32'd0);
        check("empty_busy", busy,  32'd0);
        check("empty_plot", plot,  32'd0);
        step();
        check("empty_seen", go_seen, 32'd0);

        // Mux: channel 1 drives the adapter, channel 0 strobe must not leak
        ch_x[0 +: X_W]   = 9'd5;
        ch_y[0 +: Y_W]   = 8'd7;
        ch_color[0 +: C_W] = 3'd1;
        ch_x[X_W +: X_W] = 9'd200;
        ch_y[Y_W +: Y_W] = 8'd100;
        ch_color[C_W +: C_W] = 3'd4;
        ch_plot = 3'b011;
        start(3'b010);
        check("mux_launch_plot", plot, 32'd0);
        step();
        step();
        check("mux_x",     x,      32'd200);
        check("mux_y",     y,      32'd100);
        check("mux_color", color,  32'd4);
        check("mux_plot",  plot,   32'd1);
        check("mux_cur",   cur_ch, 32'd1);
        ch_plot = 3'b001;
        step();
        check("mux_noleak", plot, 32'd0);
        check("mux_x_hold", x,    32'd200);
        pulse_done(3'b010);
        check("mux_done",  done, 32'd1);
        check("mux_fin_plot", plot, 32'd0);
        step();
        check("mux_idle_x", x, 32'd200);

        // Restart mid-WAIT on channel 1; late channel-1 done is ignored
        ch_plot = 3'b000;
        start(3'b010);
        step();
        go_seen = 3'b000;
        start(3'b011);
        check("rs_go0",   ch_go,  32'b001);
        check("rs_cur0",  cur_ch, 32'd0);
        check("rs_busy",  busy,   32'd1);
        step();
        pulse_done(3'b010);
        check("rs_ign_go",   ch_go,  32'd0);
        check("rs_ign_cur",  cur_ch, 32'd0);
        check("rs_ign_done", done,   32'd0);
        pulse_done(3'b001);
        check("rs_go1", ch_go, 32'b010);
        step();
        pulse_done(3'b010);
        check("rs_done", done, 32'd1);
        check("rs_seen", go_seen, 32'b011);
        step();

        // go and current done together: go wins
        start(3'b011);
        step();
        ch_done = 3'b001;
        ch_en   = 3'b100;
        go      = 1'b1;
        step();
        go      = 1'b0;
        ch_done = 3'b000;
        check("gowins_go",  ch_go,  32'b100);
        check("gowins_cur", cur_ch, 32'd2);
        step();
        pulse_done(3'b100);
        check("gowins_done", done, 32'd1);
        step();

        // Async reset mid-WAIT on channel 2 with pixels flowing
        ch_x[2*X_W +: X_W] = 9'd300;
        ch_plot = 3'b100;
        start(3'b100);
        step();
        step();
        check("ar_pre_x",    x,    32'd300);
        check("ar_pre_plot", plot, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("ar_busy", busy,   32'd0);
        check("ar_cur",  cur_ch, 32'd0);
        check("ar_pix",  {x, y, color, plot}, 32'd0);
        check("ar_go",   ch_go,  32'd0);
        #1 reset_n = 1'b1;
        ch_plot = 3'b000;
        step();
        check("ar_idle_done", done, 32'd0);

`ifdef DRAW_SEQ_TIMEOUT_EN
        // Watchdog: channel 0 never finishes
        start(3'b011);
        step();
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("wd_still_wait", ch_go, 32'd0);
        step();
        check("wd_adv_go",  ch_go,       32'b010);
        check("wd_err",     timeout_err, 32'd1);
        step();
        pulse_done(3'b010);
        check("wd_done",     done,        32'd1);
        check("wd_err_hold", timeout_err, 32'd1);
        step();
        start(3'b001);
        check("wd_err_clr", timeout_err, 32'd0);
        step();
        pulse_done(3'b001);
        step();
`else
        check("terr_tied0", timeout_err, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
Parametrised N-channel draw sequencer for the VGA pixel path. On one start pulse it launches each enabled drawer channel in ascending index order and waits for each channel's done. It forwards the active channel's x/y/color/plot to the single VGA adapter port through a registered mux. It supersedes the fixed three-stage erase-erase-draw chains, with a per-frame channel enable mask, restart-on-go, status outputs and an optional watchdog.

Parameters:
NUM_CH, 3, number of drawer channels (2..8)
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
C_W, 3, colour width
TIMEOUT, 4096, watchdog limit in cycles per channel (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
go  in  1  start pulse (e.g. 60 Hz frame tick)
ch_en  in  NUM_CH  channel enable mask, sampled on accepted go
ch_go  out  NUM_CH  one-cycle launch pulse per channel
ch_done  in  NUM_CH  per-channel completion pulse
ch_x  in  NUM_CH*X_W  packed channel x, channel i at bits [i*X_W +: X_W]
ch_y  in  NUM_CH*Y_W  packed channel y
ch_color  in  NUM_CH*C_W  packed channel colour
ch_plot  in  NUM_CH  channel plot strobes
x  out  X_W  muxed x to VGA adapter
y  out  Y_W  muxed y
color  out  C_W  muxed colour
plot  out  1  muxed plot
cur_ch  out  clog2(NUM_CH)  index of the active channel
busy  out  1  high from the cycle after accepted go until done
done  out  1  one-cycle pulse when the sequence completes
timeout_err  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (async, reset_n=0): state IDLE; mask=0; cur_ch=0; ch_go=0; x=0; y=0; color=0; plot=0; busy=0; done=0; timeout_err=0.
- States are IDLE, LAUNCH, WAIT, FINISH. All outputs are registered.
- IDLE + go:
  - Latch mask<=ch_en.
  - If the mask is nonzero: cur_ch<=lowest set index; go to LAUNCH.
  - If the mask is zero: go to FINISH.
- LAUNCH: ch_go[cur_ch]=1 for exactly this cycle. Next state is WAIT.
- WAIT:
  - On ch_done[cur_ch]=1, find the lowest set mask bit strictly above cur_ch.
  - If one exists: cur_ch<=that index; go to LAUNCH.
  - Otherwise go to FINISH.
  - ch_done on non-current channels is ignored in every state. ch_done in LAUNCH is ignored.
- FINISH: done=1 for one cycle; busy=0; next state is IDLE.
- Latency:
  - go sampled at edge k gives ch_go at cycle k+1.
  - The last ch_done at edge m gives done at cycle m+1.
  - Empty mask: done at k+1, no ch_go.
- Mux:
  - At each edge, x/y/color/plot <= channel cur_ch inputs, i.e. one cycle latency.
  - plot is forced 0 in IDLE, LAUNCH and FINISH, and in the cycle a channel switch occurs. This stops a stale channel's strobe from leaking.
  - x/y/color hold their last values when not in WAIT.
- go while busy (any non-IDLE state): restart.
  - Re-sample ch_en, go to LAUNCH on the new lowest enabled channel. If the new mask is zero, go to FINISH.
  - plot is forced 0 that cycle.
  - The aborted channel receives no further ch_go. Its drawer is responsible for being re-startable.
- go and ch_done[cur_ch] in the same cycle: go wins (restart).
- NUM_CH is not a power of two: cur_ch never exceeds NUM_CH-1. Out-of-range selects give zeros.

Optional Feature:
DRAW_SEQ_TIMEOUT_EN
- Defined:
  - A counter clears on each LAUNCH and increments in WAIT.
  - On reaching TIMEOUT-1 without ch_done[cur_ch], the sequencer advances exactly as if done had arrived, and sets timeout_err=1 (sticky).
  - timeout_err clears only on reset or accepted go from IDLE.
- Undefined: no counter; WAIT lasts indefinitely; timeout_err is constant 0.

Decomposition:
- Package draw_seq_pkg:
  - state enum (IDLE, LAUNCH, WAIT, FINISH);
  - default widths X_W_DEF=9, Y_W_DEF=8, C_W_DEF=3;
  - helper function for clog2 of NUM_CH (minimum 1).
- One sub-module, draw_seq_next_ch: combinational priority finder. Inputs are mask and a start index (plus an "inclusive" flag). Outputs are next index and found.

Test Plan:
- NUM_CH=3, ch_en=3'b111, go:
  - ch_go order 001, 010, 100, each one cycle after the previous done;
  - done one cycle after ch_done[2];
  - busy high throughout.
- ch_en=3'b101: ch_go[1] is never asserted; channel 2 launches the cycle after ch_done[0]+1.
- ch_en=0, go: done pulses at k+1; no ch_go; plot stays 0.
- Mux check:
  - Channel 1 drives x=9'd200, y=8'd100, color=3'd4, plot=1; outputs match one cycle later with cur_ch=1.
  - ch_plot[0]=1 simultaneously must not reach plot.
- Mid-WAIT on channel 1, assert go with ch_en=3'b011: restart with ch_go[0]; the channel-1 done that follows is ignored. Also assert reset_n=0 mid-WAIT: all outputs return to 0 immediately (async).
- With DRAW_SEQ_TIMEOUT_EN and TIMEOUT=16:
  - Channel 0 never signals done; advance occurs 16 cycles after entering WAIT and timeout_err=1.
  - timeout_err stays 1 through done and clears on the next accepted go.
